// File: rtl/fifo_pkg.sv
// Shared constants and the wrapping pointer increment for the FWFT FIFO.
package fifo_pkg;
  localparam int FIFO_DEF_DATA_WIDTH = 128;
  localparam int FIFO_DEF_DEPTH      = 11;

  // Wraps at depth-1 by explicit compare so non power-of-two depths work.
  function automatic logic [31:0] fifo_next_ptr(input logic [31:0] ptr, input logic [31:0] depth);
    return (ptr == depth - 32'd1) ? 32'd0 : ptr + 32'd1;
  endfunction
endpackage

// File: rtl/fifo_ptr.sv
// Wrapping FIFO pointer with synchronous clear; used for both write and read sides.
module fifo_ptr
  import fifo_pkg::*;
#(
  parameter int DEPTH      = FIFO_DEF_DEPTH,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clr,
  input  logic                  inc,
  output logic [ADDR_WIDTH-1:0] ptr
);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  ptr <= '0;
    else if (clr)  ptr <= '0;
    else if (inc)  ptr <= ADDR_WIDTH'(fifo_next_ptr(32'(ptr), 32'(DEPTH)));
  end
endmodule

// File: rtl/fifo_fwft.sv
// First-word-fall-through FIFO with fill count, thresholds and flush.
// Sticky overflow/underflow flags are built only when FIFO_ERR_FLAGS_EN is defined.
module fifo_fwft
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DEF_DATA_WIDTH,
  parameter int DEPTH      = FIFO_DEF_DEPTH,
  parameter int AF_MARGIN  = 2,
  parameter int AE_MARGIN  = 2
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          fifo_flush,
  input  logic                          fifo_write_e,
  input  logic [DATA_WIDTH-1:0]         fifo_wdata,
  input  logic                          fifo_read_e,
  output logic [DATA_WIDTH-1:0]         fifo_rdata,
  output logic                          fifo_valid,
  output logic                          fifo_full,
  output logic                          fifo_empty,
  output logic                          fifo_almost_full,
  output logic                          fifo_almost_empty,
  output logic [$clog2(DEPTH+1)-1:0]    fifo_count,
  input  logic                          fifo_err_clr,
  output logic                          fifo_overflow,
  output logic                          fifo_underflow
);
  localparam int ADDR_WIDTH = $clog2(DEPTH);
  localparam int CNT_WIDTH  = $clog2(DEPTH+1);

  logic [DEPTH-1:0][DATA_WIDTH-1:0] mem;
  logic [ADDR_WIDTH-1:0]            wr_ptr, rd_ptr;
  logic [CNT_WIDTH-1:0]             count;
  logic                             rd_acc, wr_acc;

  assign fifo_empty        = (count == '0);
  assign fifo_full         = (count == CNT_WIDTH'(DEPTH));
  assign fifo_almost_full  = (count >= CNT_WIDTH'(DEPTH - AF_MARGIN));
  assign fifo_almost_empty = (count <= CNT_WIDTH'(AE_MARGIN));
  assign fifo_count        = count;
  assign fifo_valid        = ~fifo_empty;

  // A full FIFO still takes a write when the head pops on the same edge.
  assign rd_acc = fifo_read_e & ~fifo_empty;
  assign wr_acc = fifo_write_e & (~fifo_full | rd_acc);

  fifo_ptr #(.DEPTH(DEPTH), .ADDR_WIDTH(ADDR_WIDTH)) u_wr_ptr (
    .clk(clk), .reset_n(reset_n), .clr(fifo_flush), .inc(wr_acc), .ptr(wr_ptr)
  );

  fifo_ptr #(.DEPTH(DEPTH), .ADDR_WIDTH(ADDR_WIDTH)) u_rd_ptr (
    .clk(clk), .reset_n(reset_n), .clr(fifo_flush), .inc(rd_acc), .ptr(rd_ptr)
  );

  always_ff @(posedge clk) begin
    if (wr_acc && !fifo_flush) mem[wr_ptr] <= fifo_wdata;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                count <= '0;
    else if (fifo_flush)         count <= '0;
    else if (wr_acc && !rd_acc)  count <= count + 1'b1;
    else if (rd_acc && !wr_acc)  count <= count - 1'b1;
  end

  assign fifo_rdata = fifo_empty ? '0 : mem[rd_ptr];

`ifdef FIFO_ERR_FLAGS_EN
  logic ovf_q, udf_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else if (fifo_err_clr) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      if (fifo_write_e && fifo_full && !rd_acc && !fifo_flush) ovf_q <= 1'b1;
      if (fifo_read_e && fifo_empty && !fifo_flush)            udf_q <= 1'b1;
    end
  end

  assign fifo_overflow  = ovf_q;
  assign fifo_underflow = udf_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = fifo_err_clr;
  assign fifo_overflow  = 1'b0;
  assign fifo_underflow = 1'b0;
`endif
endmodule
